// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter.
// Exports W (data width), op_t and the eight opcode values.
package alu_pkg;
  localparam int W = 4;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'd0;
  localparam op_t OP_SUB = 3'd1;
  localparam op_t OP_NEG = 3'd2;
  localparam op_t OP_AND = 3'd3;
  localparam op_t OP_OR  = 3'd4;
  localparam op_t OP_XOR = 3'd5;
  localparam op_t OP_CMP = 3'd6;
  localparam op_t OP_EQ  = 3'd7;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle of the ALU arbiter.
// master: requesters + consumer side; slave: the arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  op_t          req0_op;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  op_t          req1_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_y;
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_y, cnt0, cnt1
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_y, cnt0, cnt1
  );
endinterface

// File: rtl/alu_arbiter_alu4.sv
// Combinational 4-bit signed ALU (a, b, op -> y).
// Ports: a, b operands; op opcode; y result.
module alu4
  import alu_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_t          op,
  output logic [W-1:0] y
);
  logic signed [W-1:0] sa;
  logic signed [W-1:0] sb;

  assign sa = a;
  assign sb = b;

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_NEG: y = -a;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_CMP: y = (sa > sb) ? 4'd0 : 4'd1;
      OP_EQ:  y = (a == b) ? 4'd1 : 4'd0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters.
// Ports: clk, rst (async high), bus (slave side of alu_arbiter_if).
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  logic         prio;
  logic         can_accept;
  logic         g0;
  logic         g1;
  logic         acc;
  logic         retire;
  logic [W-1:0] a;
  logic [W-1:0] b;
  op_t          op;
  logic [W-1:0] y;

  assign can_accept = !bus.rsp_valid || bus.rsp_ready;

  // A lone valid wins; on conflict prio picks the winner.
  assign g0 = bus.req0_valid && (!bus.req1_valid || !prio);
  assign g1 = bus.req1_valid && (!bus.req0_valid || prio);

  assign bus.req0_ready = !rst && can_accept && g0;
  assign bus.req1_ready = !rst && can_accept && g1;

  assign acc    = bus.req0_ready || bus.req1_ready;
  assign retire = bus.rsp_valid && bus.rsp_ready;

  assign a  = g1 ? bus.req1_a  : bus.req0_a;
  assign b  = g1 ? bus.req1_b  : bus.req0_b;
  assign op = g1 ? bus.req1_op : bus.req0_op;

  alu4 u_alu (
    .a  (a),
    .b  (b),
    .op (op),
    .y  (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_y     <= '0;
      bus.cnt0      <= '0;
      bus.cnt1      <= '0;
      prio          <= 1'b0;
    end else begin
      if (retire && !bus.rsp_id && bus.cnt0 != 8'hff)
        bus.cnt0 <= bus.cnt0 + 8'd1;
      if (retire && bus.rsp_id && bus.cnt1 != 8'hff)
        bus.cnt1 <= bus.cnt1 + 8'd1;
      if (acc) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id    <= g1;
        bus.rsp_y     <= y;
        prio          <= !g1;
      end else if (retire) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter.
// Reference model: integer ALU + pending-slot/prio/count bookkeeping.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  bit m_valid;
  int m_id, m_y, m_prio;
  int m_cnt[2];

  function automatic int wrap4(int x);
    return ((x % 16) + 16) % 16;
  endfunction

  function automatic int sx(int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  function automatic int ref_alu(int a, int b, int op);
    case (op)
      0: return wrap4(sx(a) + sx(b));
      1: return wrap4(sx(a) - sx(b));
      2: return wrap4(-sx(a));
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (sx(a) > sx(b)) ? 0 : 1;
      default: return (a == b) ? 1 : 0;
    endcase
  endfunction

  function automatic bit ref_ready(int n);
    bit v[2];
    v[0] = bus.req0_valid;
    v[1] = bus.req1_valid;
    if (m_valid && !bus.rsp_ready) return 0;
    if (!v[n]) return 0;
    if (v[1-n]) return m_prio == n;
    return 1;
  endfunction

  function automatic logic [21:0] ref_state();
    logic [3:0] y;
    logic [7:0] c0, c1;
    y = m_y[3:0];
    c0 = m_cnt[0][7:0];
    c1 = m_cnt[1][7:0];
    if (!m_valid) return {1'b0, 5'b0, c0, c1};
    return {1'b1, m_id[0], y, c0, c1};
  endfunction

  function automatic logic [21:0] dut_state();
    if (bus.rsp_valid !== 1'b1)
      return {bus.rsp_valid, 5'b0, bus.cnt0, bus.cnt1};
    return {1'b1, bus.rsp_id, bus.rsp_y, bus.cnt0, bus.cnt1};
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_id = 0;
    m_y = 0;
    m_prio = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic set_req(int n, bit v, int a, int b, int op);
    if (n == 0) begin
      bus.req0_valid = v;
      bus.req0_a = a[3:0];
      bus.req0_b = b[3:0];
      bus.req0_op = op[2:0];
    end else begin
      bus.req1_valid = v;
      bus.req1_a = a[3:0];
      bus.req1_b = b[3:0];
      bus.req1_op = op[2:0];
    end
  endtask

  task automatic rand_req(int n, bit v);
    set_req(n, v, $urandom_range(15), $urandom_range(15),
            $urandom_range(7));
  endtask

  // Advance one edge and update the model; ends 1 time unit after it.
  task automatic tick();
    bit a0, a1, ret;
    int y0, y1;
    a0 = ref_ready(0);
    a1 = ref_ready(1);
    ret = m_valid && bus.rsp_ready;
    y0 = ref_alu(bus.req0_a, bus.req0_b, bus.req0_op);
    y1 = ref_alu(bus.req1_a, bus.req1_b, bus.req1_op);
    @(posedge clk);
    if (ret && m_cnt[m_id] < 255) m_cnt[m_id]++;
    if (a0 || a1) begin
      m_valid = 1;
      m_id = a1 ? 1 : 0;
      m_y = a1 ? y1 : y0;
      m_prio = 1 - m_id;
    end else if (ret) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] rdy;
    rst = 1'b1;
    set_req(0, 1, 1, 2, 0);
    set_req(1, 1, 3, 4, 0);
    bus.rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rdy = {bus.req1_ready, bus.req0_ready};
    vectors++;
    if (rdy !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 00", rdy);
    end
    vectors++;
    if (dut_state() !== 22'd0 || bus.rsp_id !== 1'b0 ||
        bus.rsp_y !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state got %h want 0", dut_state());
    end
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    #1;
  endtask

  task automatic test_directed();
    int a[4] = '{3, 7, 14, 5};
    int b[4] = '{4, 1, 1, 5};
    int o[4] = '{0, 0, 6, 7};
    int e[4] = '{7, 8, 1, 1};
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, a[i], b[i], o[i]);
      set_req(1, 0, 0, 0, 0);
      bus.rsp_ready = 1'b0;
      #1;
      vectors++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL dir_ready[%0d] got %b%b want 01", i,
                 bus.req1_ready, bus.req0_ready);
      end
      tick();
      set_req(0, 0, 0, 0, 0);
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 ||
          bus.rsp_y !== e[i][3:0]) begin
        miscompares++;
        $display("FAIL dir_rsp[%0d] got v%b id%b y%h want 1 0 %h", i,
                 bus.rsp_valid, bus.rsp_id, bus.rsp_y, e[i][3:0]);
      end
      bus.rsp_ready = 1'b1;
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.cnt0 !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL dir_retire[%0d] got v%b cnt0 %0d want 0 %0d",
                 i, bus.rsp_valid, bus.cnt0, i + 1);
      end
    end
  endtask

  task automatic test_alternate();
    int first;
    int g;
    bus.rsp_ready = 1'b1;
    first = m_prio;
    for (int i = 0; i < 20; i++) begin
      rand_req(0, 1);
      rand_req(1, 1);
      #1;
      g = (first + i) % 2;
      vectors++;
      if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1)) begin
        miscompares++;
        $display("FAIL alt_grant[%0d] got %b%b want grant %0d", i,
                 bus.req1_ready, bus.req0_ready, g);
      end
      tick();
      vectors++;
      if (dut_state() !== ref_state()) begin
        miscompares++;
        $display("FAIL alt_rsp[%0d] got %h want %h", i,
                 dut_state(), ref_state());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [21:0] held;
    bus.rsp_ready = 1'b1;
    rand_req(0, 1);
    rand_req(1, 1);
    tick();
    held = ref_state();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_req(0, 1);
      rand_req(1, 1);
      #1;
      vectors++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_ready[%0d] got %b%b want 00", i,
                 bus.req1_ready, bus.req0_ready);
      end
      tick();
      vectors++;
      if (dut_state() !== held) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got %h want %h", i,
                 dut_state(), held);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    vectors++;
    if ((bus.req0_ready | bus.req1_ready) !== 1'b1 ||
        bus.req0_ready !== ref_ready(0)) begin
      miscompares++;
      $display("FAIL bp_release got %b%b want one grant",
               bus.req1_ready, bus.req0_ready);
    end
    tick();
    vectors++;
    if (dut_state() !== ref_state() || bus.rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_swap got %h want %h", dut_state(), ref_state());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      rand_req(0, 1'($urandom_range(1)));
      rand_req(1, 1'($urandom_range(1)));
      bus.rsp_ready = 1'($urandom_range(3) != 0);
      #1;
      vectors++;
      if (bus.req0_ready !== ref_ready(0) ||
          bus.req1_ready !== ref_ready(1)) begin
        miscompares++;
        $display("FAIL rnd_ready[%0d] got %b%b want %b%b", i,
                 bus.req1_ready, bus.req0_ready,
                 ref_ready(1), ref_ready(0));
      end
      tick();
      vectors++;
      if (dut_state() !== ref_state()) begin
        miscompares++;
        $display("FAIL rnd_rsp[%0d] got %h want %h", i,
                 dut_state(), ref_state());
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] c0;
    bus.rsp_ready = 1'b1;
    set_req(0, 0, 0, 0, 0);
    rand_req(1, 0);
    tick();
    tick();
    c0 = bus.cnt0;
    for (int i = 0; i < 260; i++) begin
      rand_req(1, 1);
      tick();
    end
    set_req(1, 0, 0, 0, 0);
    tick();
    vectors++;
    if (bus.cnt1 !== 8'd255 || bus.cnt0 !== c0) begin
      miscompares++;
      $display("FAIL sat got cnt1 %0d cnt0 %0d want 255 %0d",
               bus.cnt1, bus.cnt0, c0);
    end
    vectors++;
    if (dut_state() !== ref_state()) begin
      miscompares++;
      $display("FAIL sat_model got %h want %h", dut_state(), ref_state());
    end
  endtask

  task automatic test_async_reset();
    bus.rsp_ready = 1'b0;
    rand_req(0, 1);
    set_req(1, 0, 0, 0, 0);
    tick();
    set_req(0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.cnt0 !== 8'd0 ||
        bus.cnt1 !== 8'd0) begin
      miscompares++;
      $display("FAIL async_rst got v%b c0 %0d c1 %0d want 0 0 0",
               bus.rsp_valid, bus.cnt0, bus.cnt1);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    rand_req(0, 1);
    rand_req(1, 1);
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL post_rst_grant got %b%b want 01",
               bus.req1_ready, bus.req0_ready);
    end
    tick();
    vectors++;
    if (dut_state() !== ref_state()) begin
      miscompares++;
      $display("FAIL post_rst_rsp got %h want %h",
               dut_state(), ref_state());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_alternate();
    test_backpressure();
    test_random();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
